// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 block padder.
// Block geometry, padding constants and the FSM state set.
package md5_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    EXTRA = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [511:0] md5_block_t;

endpackage

// File: rtl/md5_block_padder.sv
// Byte stream to padded 512-bit MD5 blocks.
// Adds 0x80, zero fill, LE bit length, extra block.
module md5_block_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  state_t           state;
  logic [7:0]       bytes_q [BLOCK_BYTES];
  logic [5:0]       idx;
  logic [LEN_W-1:0] bitlen;
  logic             first;
  logic             fin;
  logic             extra;
  logic             pend;
  logic [63:0]      len64;
  md5_block_t       flat;

  assign len64 = 64'(bitlen);

  // Flatten the byte buffer, byte i at bits [8i+7:8i].
  always_comb begin
    flat = '0;
    for (int i = 0; i < BLOCK_BYTES; i++)
      flat[8*i +: 8] = bytes_q[i];
  end

  assign blk_valid = (state == EMIT);
  assign blk_data  = blk_valid ? flat : '0;
  assign blk_first = blk_valid & first;
  assign blk_last  = blk_valid & fin;
  assign in_ready  = reset & (state == FILL);

  // Block assembly FSM: fill, pad, extra length block, emit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      idx    <= '0;
      bitlen <= '0;
      first  <= 1'b1;
      fin    <= 1'b0;
      extra  <= 1'b0;
      pend   <= 1'b0;
      for (int i = 0; i < BLOCK_BYTES; i++)
        bytes_q[i] <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            bytes_q[idx] <= in_data;
            idx          <= idx + 6'd1;
            bitlen       <= bitlen + LEN_W'(8);
            if (idx == 6'd63) begin
              state <= EMIT;
              pend  <= in_last;
            end else if (in_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (6'(i) == idx)
              bytes_q[i] <= PAD_BYTE;
            else if (6'(i) > idx)
              bytes_q[i] <= '0;
          end
          if (idx <= 6'd55) begin
            for (int k = 0; k < 8; k++)
              bytes_q[LEN_OFFSET+k] <= len64[8*k +: 8];
            fin <= 1'b1;
          end else begin
            fin   <= 1'b0;
            extra <= 1'b1;
          end
          state <= EMIT;
        end
        EXTRA: begin
          for (int i = 0; i < LEN_OFFSET; i++)
            bytes_q[i] <= '0;
          for (int k = 0; k < 8; k++)
            bytes_q[LEN_OFFSET+k] <= len64[8*k +: 8];
          fin   <= 1'b1;
          state <= EMIT;
        end
        EMIT: begin
          if (blk_ready) begin
            for (int i = 0; i < BLOCK_BYTES; i++)
              bytes_q[i] <= '0;
            idx   <= '0;
            first <= 1'b0;
            if (fin) begin
              state  <= FILL;
              bitlen <= '0;
              first  <= 1'b1;
              fin    <= 1'b0;
            end else if (extra) begin
              state <= EXTRA;
              extra <= 1'b0;
            end else if (pend) begin
              state <= PAD;
              pend  <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end
      endcase
    end
  end

endmodule
